// File: rtl/change_pkg.sv
// Shared types for the change-making transaction controller: coin encodings,
// FSM states, amount/count typedefs and small arithmetic helpers.
package change_pkg;

  typedef logic [3:0] amount_t;
  typedef logic [1:0] cnt_t;

  typedef enum logic [2:0] {
    COIN_NONE = 3'd0,
    COIN_1    = 3'd1,
    COIN_3    = 3'd3,
    COIN_5    = 3'd5
  } coin_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    FINISH
  } state_e;

  function automatic logic is_legal(input logic [2:0] v);
    return (v == 3'd1) || (v == 3'd3) || (v == 3'd5);
  endfunction

  // 4-bit add that clamps at 15 instead of wrapping.
  function automatic amount_t sat_add(input amount_t a, input logic [2:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

endpackage

// File: rtl/change_txn_ctrl_if.sv
// Handshake/bus bundle between the change controller and the acceptor,
// dispenser and front panel. slave = controller side, master = driver side.
interface change_txn_ctrl_if;
  import change_pkg::*;

  logic       start;
  amount_t    cost;
  logic       cancel;
  logic       coin_valid;
  logic [2:0] coin_val;
  logic       coin_ready;
  logic       refill;
  cnt_t       refill_p;
  cnt_t       refill_t;
  cnt_t       refill_c;
  logic       disp_valid;
  logic [2:0] disp_coin;
  logic       disp_ready;
  amount_t    paid;
  amount_t    remaining;
  logic       done;
  logic       exact;
  logic       short_change;
  logic       busy;

  modport slave (
    input  start, cost, cancel, coin_valid, coin_val, refill,
           refill_p, refill_t, refill_c, disp_ready,
    output coin_ready, disp_valid, disp_coin, paid, remaining,
           done, exact, short_change, busy
  );

  modport master (
    output start, cost, cancel, coin_valid, coin_val, refill,
           refill_p, refill_t, refill_c, disp_ready,
    input  coin_ready, disp_valid, disp_coin, paid, remaining,
           done, exact, short_change, busy
  );
endinterface

// File: rtl/change_txn_ctrl_coin_select.sv
// Greedy change-coin picker: largest of 5/3/1 that fits the remaining change
// and is in stock, suppressed when allow is low.
module coin_select
  import change_pkg::*;
(
  input  amount_t change,
  input  cnt_t    inv_p,
  input  cnt_t    inv_t,
  input  cnt_t    inv_c,
  input  logic    allow,
  output coin_e   coin,
  output amount_t value
);
  always_comb begin
    coin  = COIN_NONE;
    value = '0;
    if (allow) begin
      if (change >= 4'd5 && inv_p != '0) begin
        coin  = COIN_5;
        value = 4'd5;
      end else if (change >= 4'd3 && inv_t != '0) begin
        coin  = COIN_3;
        value = 4'd3;
      end else if (change >= 4'd1 && inv_c != '0) begin
        coin  = COIN_1;
        value = 4'd1;
      end
    end
  end
endmodule

// File: rtl/change_txn_ctrl.sv
// Transaction controller: collects coins against a cost, then dispenses change
// one coin per handshake. Optional macro COIN_RECYCLE_EN feeds inserted coins
// into the change inventory.
module change_txn_ctrl
  import change_pkg::*;
#(
  parameter int unsigned MAX_COINS = 2
) (
  input logic          clock,
  input logic          reset_L,
  change_txn_ctrl_if.slave bus
);
  localparam logic [2:0] MAX_C = 3'(MAX_COINS);

  state_e     state, state_nx;
  amount_t    cost_r, paid_r, change_r, remaining_r, dval_r;
  logic [2:0] count_r;
  cnt_t       inv_p, inv_t, inv_c;
  logic       exact_r, short_r, dv_r;
  coin_e      dcoin_r;

  coin_e      pick;
  amount_t    pick_val;
  logic       coin_ready_c, coin_acc, start_ok;
  amount_t    paid_new;

  assign start_ok = bus.start && !bus.refill && (bus.cost != '0);
  assign coin_acc = bus.coin_valid && coin_ready_c && is_legal(bus.coin_val);
  assign paid_new = coin_acc ? sat_add(paid_r, bus.coin_val) : paid_r;

  coin_select u_sel (
    .change (change_r),
    .inv_p  (inv_p),
    .inv_t  (inv_t),
    .inv_c  (inv_c),
    .allow  (count_r < MAX_C),
    .coin   (pick),
    .value  (pick_val)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  // Settlement uses paid_new so a coin landing in the evaluation cycle is never lost.
  always_comb begin
    state_nx     = state;
    coin_ready_c = 1'b0;
    unique case (state)
      IDLE:     if (start_ok) state_nx = COLLECT;
      COLLECT: begin
        coin_ready_c = 1'b1;
        if (paid_r >= cost_r)
          state_nx = (paid_new == cost_r) ? FINISH : DISPENSE;
        else if (bus.cancel)
          state_nx = (paid_new == '0) ? FINISH : DISPENSE;
      end
      DISPENSE: if (!dv_r && pick == COIN_NONE) state_nx = FINISH;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      cost_r      <= '0;
      paid_r      <= '0;
      change_r    <= '0;
      remaining_r <= '0;
      dval_r      <= '0;
      count_r     <= '0;
      inv_p       <= '0;
      inv_t       <= '0;
      inv_c       <= '0;
      exact_r     <= 1'b0;
      short_r     <= 1'b0;
      dv_r        <= 1'b0;
      dcoin_r     <= COIN_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.refill) begin
            inv_p <= bus.refill_p;
            inv_t <= bus.refill_t;
            inv_c <= bus.refill_c;
          end else if (start_ok) begin
            cost_r      <= bus.cost;
            paid_r      <= '0;
            change_r    <= '0;
            count_r     <= '0;
            exact_r     <= 1'b0;
            short_r     <= 1'b0;
            remaining_r <= '0;
          end
        end
        COLLECT: begin
          paid_r <= paid_new;
`ifdef COIN_RECYCLE_EN
          if (coin_acc) begin
            unique case (bus.coin_val)
              3'd5:    if (inv_p != 2'd3) inv_p <= inv_p + 1'b1;
              3'd3:    if (inv_t != 2'd3) inv_t <= inv_t + 1'b1;
              default: if (inv_c != 2'd3) inv_c <= inv_c + 1'b1;
            endcase
          end
`endif
          if (paid_r >= cost_r) begin
            if (paid_new == cost_r) exact_r  <= 1'b1;
            else                    change_r <= paid_new - cost_r;
          end else if (bus.cancel) begin
            change_r <= paid_new;
          end
        end
        DISPENSE: begin
          if (dv_r) begin
            if (bus.disp_ready) begin
              dv_r     <= 1'b0;
              change_r <= change_r - dval_r;
              count_r  <= count_r + 3'd1;
              unique case (dcoin_r)
                COIN_5:  inv_p <= inv_p - 1'b1;
                COIN_3:  inv_t <= inv_t - 1'b1;
                COIN_1:  inv_c <= inv_c - 1'b1;
                default: ;
              endcase
            end
          end else if (pick != COIN_NONE) begin
            dv_r    <= 1'b1;
            dcoin_r <= pick;
            dval_r  <= pick_val;
          end
        end
        default: ;
      endcase
      if (state != FINISH && state_nx == FINISH) begin
        remaining_r <= change_r;
        short_r     <= (change_r != '0);
      end
    end
  end

  assign bus.coin_ready   = coin_ready_c;
  assign bus.disp_valid   = dv_r;
  assign bus.disp_coin    = dcoin_r;
  assign bus.paid         = paid_r;
  assign bus.remaining    = remaining_r;
  assign bus.done         = (state == FINISH);
  assign bus.exact        = exact_r;
  assign bus.short_change = short_r;
  assign bus.busy         = (state != IDLE);
endmodule

// File: doc/change_txn_ctrl.md
Name: change_txn_ctrl

Overview:
- Sequential transaction controller for the change-making datapath.
- Collects inserted coins against a loaded cost, then dispenses change one coin per handshake. Coins are picked greedily (5, then 3, then 1) from a tracked 2-bit-per-type inventory.
- Reports exact-payment, short-change and leftover amount at end of each transaction.
- Sits between the coin acceptor / dispenser mechanics and the front-panel LEDs.

Parameters:
- MAX_COINS, 2: maximum coins dispensed per transaction; legal range 1..7.

Ports:
- clock  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- start  in  1  begins a transaction when in IDLE; samples cost.
- cost  in  4  item cost, unsigned.
- cancel  in  1  in COLLECT: abort and refund all paid.
- coin_valid  in  1  acceptor presents a coin.
- coin_val  in  3  inserted coin value; only 1, 3 and 5 are legal.
- coin_ready  out  1  controller accepts a coin this cycle.
- refill  in  1  loads inventory; honoured only in IDLE.
- refill_p  in  2  pentagon (5) count to load.
- refill_t  in  2  triangle (3) count to load.
- refill_c  in  2  circle (1) count to load.
- disp_valid  out  1  coin offered to dispenser.
- disp_coin  out  3  coin value offered: 5, 3 or 1.
- disp_ready  in  1  dispenser takes the coin.
- paid  out  4  running paid total.
- remaining  out  4  undispensed change; valid when done=1.
- done  out  1  one-cycle end-of-transaction pulse.
- exact  out  1  held: last transaction paid == cost, with cost != 0.
- short_change  out  1  held: last transaction ended with remaining != 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; paid=0; change=0; count=0; inventory P/T/C=0; all outputs 0.
- IDLE:
  - start=1 with cost!=0: latch cost, clear paid, count, exact and short_change; next state COLLECT.
  - start with cost=0: ignored.
  - refill: loads P/T/C next cycle.
  - start and refill in the same cycle: refill is applied, start is ignored.
- COLLECT:
  - coin_ready=1.
  - On coin_valid & coin_ready with a legal value: paid += value, saturating at 15.
  - Illegal value (0, 2, 4, 6, 7): handshake completes, paid unchanged.
  - The next cycle evaluates the updated paid:
    - paid == cost: go to FINISH with exact=1.
    - paid > cost: change = paid - cost; go to DISPENSE.
  - cancel=1: change = paid (paid=0 goes straight to FINISH); go to DISPENSE.
  - cancel and a coin in the same cycle: the coin is accepted first, then the refund covers the new paid.
- DISPENSE:
  - coin_ready=0.
  - Eligible coin is the first of 5, 3, 1 with value <= change and inventory > 0.
  - If an eligible coin exists and count < MAX_COINS:
    - disp_valid=1; disp_coin is held stable until disp_ready.
    - On handshake: change -= coin; that inventory -= 1; count += 1.
  - The choice is re-evaluated only after a handshake, never while disp_valid is pending.
  - Otherwise: go to FINISH.
- FINISH (one cycle):
  - done=1; remaining=change; short_change=(change!=0).
  - Next state IDLE.
  - remaining, exact and short_change hold until the next accepted start.
- Widths: all arithmetic is 4-bit unsigned. Change can never underflow because coin value <= change is checked before dispensing.
- Reset mid-operation: immediate return to IDLE; inventory is cleared; a pending disp_valid drops asynchronously.

Optional Feature:
- Macro: COIN_RECYCLE_EN.
  - Defined: each legal inserted coin also increments its inventory count, saturating at 3, so it is usable as change in the same transaction. A refund after cancel may therefore return a recycled coin.
  - Undefined: inserted coins never touch the inventory.

Decomposition:
- Package change_pkg:
  - coin encodings COIN_NONE=0, COIN_1=1, COIN_3=3, COIN_5=5;
  - state enum IDLE/COLLECT/DISPENSE/FINISH;
  - 4-bit amount typedef and 2-bit count typedef.
- Sub-module coin_select: combinational greedy pick. Inputs change, P/T/C, allow; outputs coin and value.

Test Plan:
- Exact pay: inventory P/T/C=1/1/1; cost=8; insert 5, then 3 -> done, exact=1, no disp_valid, remaining=0.
- Greedy two-coin: inventory 1/1/1; cost=2; insert 5, then 5 (paid=10, change=8) -> dispense 5 then 3; remaining=0, short_change=0.
- Inventory-limited: inventory 0/0/1; cost=1; insert 5 (change=4) -> dispense 1; remaining=3, short_change=1.
- MAX_COINS cap: inventory 0/0/3; cost=1; insert 5 (change=4) -> two 1-coins only; remaining=2, short_change=1.
- Backpressure and cancel:
  - cost=9; insert 3 then cancel, with disp_ready held low 4 cycles -> disp_coin=3 stable throughout, one handshake, remaining=0.
  - Repeat with COIN_RECYCLE_EN on an empty inventory -> same result.
- Reset mid-DISPENSE: assert reset_L low while disp_valid=1 -> disp_valid=0 immediately, state=IDLE, inventory=0/0/0.
